rx_frame_writer: RTL

- Ingress stage for one switch port, running in the port receive clock domain (wclk).
- Takes the GMII-style byte stream from the PHY, strips the preamble and SFD, checks the FCS with CRC-32, checks length, and counts frames.
- Writes frame bytes into the write side of the port's async FIFO as 9-bit words, then appends one status word per frame.
- The read-domain frame parser consumes these words.

---
 rtl/switch_pkg.sv | 20 ++
 rtl/crc32_d8.sv | 17 +
 rtl/rx_frame_writer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared types and constants for the switch port datapath.
package switch_pkg;

   typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, STATUS, DROP} rx_state_t;

   // Bit positions inside the per-frame status word
   localparam int unsigned ST_FCS_BAD = 0;
   localparam int unsigned ST_OVF     = 1;
   localparam int unsigned ST_ER      = 2;
   localparam int unsigned ST_RUNT    = 3;
   localparam int unsigned ST_GIANT   = 4;

   localparam logic [7:0] SFD           = 8'hD5;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) next-state for one data byte.
module crc32_d8
   import switch_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/rx_frame_writer.sv
// GMII receive ingress: strips preamble/SFD, checks FCS and length, writes bytes plus
// one status word per frame into the async FIFO write side, and keeps frame counters.
module rx_frame_writer
   import switch_pkg::*;
#(
   parameter int unsigned MIN_LEN   = 64,
   parameter int unsigned MAX_LEN   = 1518,
   parameter int unsigned LEN_WIDTH = 11,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 wclk,
   input  logic                 reset,
   input  logic                 rx_dv,
   input  logic                 rx_er,
   input  logic [7:0]           rxd,
   input  logic                 fifo_full,
   output logic                 fifo_write_enable,
   output logic [8:0]           fifo_write_data,
   output logic [CNT_WIDTH-1:0] frames_ok,
   output logic [CNT_WIDTH-1:0] frames_err,
   output logic [CNT_WIDTH-1:0] frames_dropped
);

   localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
   localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

   rx_state_t            state_q, state_d;
   logic [LEN_WIDTH-1:0] length_q, length_d;
   logic [31:0]          crc_q, crc_d, crc_next;
   logic                 er_q, er_d;
   logic                 ovf_q, ovf_d;
   logic                 drop_pend_q, drop_pend_d;
   logic                 wen_q, wen_d;
   logic [8:0]           wdata_q, wdata_d;
   logic [CNT_WIDTH-1:0] ok_q, err_q, drop_q;
   logic                 ok_inc, err_inc, drop_inc;
   logic [7:0]           status;

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (rxd),
      .crc_out (crc_next)
   );

   always_comb begin
      status              = 8'h00;
      status[ST_FCS_BAD]  = (crc_q != CRC_RESIDUE);
      status[ST_OVF]      = ovf_q;
      status[ST_ER]       = er_q;
      status[ST_RUNT]     = (length_q < MIN_L);
      status[ST_GIANT]    = (length_q > MAX_L);
   end

   always_comb begin
      state_d     = state_q;
      length_d    = length_q;
      crc_d       = crc_q;
      er_d        = er_q;
      ovf_d       = ovf_q;
      drop_pend_d = drop_pend_q;
      wen_d       = 1'b0;
      wdata_d     = wdata_q;
      ok_inc      = 1'b0;
      err_inc     = 1'b0;
      drop_inc    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rx_dv) state_d = PREAMBLE;
         end
         PREAMBLE: begin
            if (!rx_dv || rx_er) begin
               state_d  = DROP;
               drop_inc = 1'b1;
            end else if (rxd == SFD) begin
               state_d  = DATA;
               length_d = '0;
               crc_d    = CRC_INIT;
               er_d     = 1'b0;
               ovf_d    = 1'b0;
            end else if (rxd != PREAMBLE_BYTE) begin
               state_d  = DROP;
               drop_inc = 1'b1;
            end
         end
         DATA: begin
            if (rx_dv) begin
               crc_d = crc_next;
               if (length_q != '1) length_d = length_q + LEN_WIDTH'(1);
               if (rx_er) er_d = 1'b1;
               // Once a byte is lost the rest of the frame is suppressed too
               if (fifo_full || ovf_q) begin
                  ovf_d = 1'b1;
               end else begin
                  wen_d   = 1'b1;
                  wdata_d = {1'b0, rxd};
               end
            end else begin
               state_d = STATUS;
            end
         end
         STATUS: begin
            if (fifo_full) begin
               if (rx_dv) drop_pend_d = 1'b1;
            end else begin
               wen_d   = 1'b1;
               wdata_d = {1'b1, status};
               if (|status[4:0]) err_inc = 1'b1;
               else              ok_inc  = 1'b1;
               if (drop_pend_q) begin
                  state_d     = DROP;
                  drop_inc    = 1'b1;
                  drop_pend_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (!rx_dv) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         length_q    <= '0;
         crc_q       <= CRC_INIT;
         er_q        <= 1'b0;
         ovf_q       <= 1'b0;
         drop_pend_q <= 1'b0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         length_q    <= length_d;
         crc_q       <= crc_d;
         er_q        <= er_d;
         ovf_q       <= ovf_d;
         drop_pend_q <= drop_pend_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
      end
   end

   // Statistics saturate at all-ones
   always_ff @(posedge wclk or posedge reset) begin
      if (reset) begin
         ok_q   <= '0;
         err_q  <= '0;
         drop_q <= '0;
      end else begin
         if (ok_inc && ok_q != '1)     ok_q   <= ok_q + CNT_WIDTH'(1);
         if (err_inc && err_q != '1)   err_q  <= err_q + CNT_WIDTH'(1);
         if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_WIDTH'(1);
      end
   end

   assign fifo_write_enable = wen_q;
   assign fifo_write_data   = wdata_q;
   assign frames_ok         = ok_q;
   assign frames_err        = err_q;
   assign frames_dropped    = drop_q;

endmodule
